// File: rtl/fb_pkg.sv
// Shared types and default geometry for the frame-buffer writer and its readers.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } fbw_state_t;

  localparam int FB_WIDTH = 16;
  localparam int FB_H_RES = 32;
  localparam int FB_V_RES = 24;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_writer.sv
// Pixel stream to double-banked frame RAM writer; swaps banks after each
// complete frame so the display side always reads a whole frame.
module fb_writer
  import fb_pkg::*;
#(
  parameter  int WIDTH = FB_WIDTH,
  parameter  int H_RES = FB_H_RES,
  parameter  int V_RES = FB_V_RES,
  localparam int DEPTH = H_RES * V_RES,
  localparam int ADDRW = $clog2(2 * DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_sof,
  input  logic             s_eol,
  output logic             wr_en,
  output logic [ADDRW-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             rd_bank,
  output logic             frame_done,
  output logic             err_sync
);

  localparam int IDXW = ADDRW - 1;
  localparam int XW   = cnt_w(H_RES);
  localparam int YW   = cnt_w(V_RES);

  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  fbw_state_t      state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic            wr_en_q, wr_en_d;
  logic [ADDRW-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic            frame_done_q, frame_done_d;
  logic            err_sync_q, err_sync_d;

  logic accept;
  logic at_eol;

  assign s_ready = (state_q != DONE);
  assign accept  = s_valid & s_ready;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    idx_d        = idx_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    err_sync_d   = 1'b0;
    at_eol       = (x_q == X_LAST);

    case (state_q)
      IDLE: begin
        if (accept && s_sof) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {wr_bank_q, {IDXW{1'b0}}};
          wr_data_d = s_data;
          idx_d     = IDXW'(1);
          x_d       = XW'(1);
          y_d       = '0;
          state_d   = WRITE;
        end
      end

      WRITE: begin
        if (accept) begin
          if (s_sof) begin
            // Restart the frame in place: the sof beat becomes pixel 0.
            err_sync_d = 1'b1;
            wr_en_d    = 1'b1;
            wr_addr_d  = {wr_bank_q, {IDXW{1'b0}}};
            wr_data_d  = s_data;
            idx_d      = IDXW'(1);
            x_d        = XW'(1);
            y_d        = '0;
          end else if (s_eol != at_eol) begin
            err_sync_d = 1'b1;
            idx_d      = '0;
            x_d        = '0;
            y_d        = '0;
            state_d    = IDLE;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = {wr_bank_q, idx_q};
            wr_data_d = s_data;
            idx_d     = idx_q + IDXW'(1);
            if (at_eol) begin
              x_d = '0;
              if (y_q == Y_LAST) begin
                frame_done_d = 1'b1;
                state_d      = DONE;
              end else begin
                y_d = y_q + YW'(1);
              end
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end

      DONE: begin
        rd_bank_d = wr_bank_q;
        wr_bank_d = ~wr_bank_q;
        idx_d     = '0;
        x_d       = '0;
        y_d       = '0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // frame_done_q is raised on entry to DONE, so it is high exactly for that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      idx_q        <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_sync_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      idx_q        <= idx_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      err_sync_q   <= err_sync_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_bank    = rd_bank_q;
  assign frame_done = frame_done_q;
  assign err_sync   = err_sync_q;

endmodule

// File: tb/tb_fb_writer.sv
// Bench for fb_writer: drives framed pixel streams, mirrors them into a sync RAM
// and compares observed writes / pulses against an arithmetic frame model.
module tb_fb_writer;
  import fb_pkg::*;

  localparam int WIDTH     = 16;
  localparam int H_RES     = 32;
  localparam int V_RES     = 24;
  localparam int DEPTH     = H_RES * V_RES;
  localparam int ADDRW     = $clog2(2 * DEPTH);
  localparam int BANK_SPAN = 1 << (ADDRW - 1);
  localparam int MEMW      = 1 << ADDRW;

  logic             clk;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_sof;
  logic             s_eol;
  logic             wr_en;
  logic [ADDRW-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_bank;
  logic             frame_done;
  logic             err_sync;

  fb_writer #(.WIDTH(WIDTH), .H_RES(H_RES), .V_RES(V_RES)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .s_eol(s_eol),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_bank(rd_bank), .frame_done(frame_done), .err_sync(err_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame RAM: write port from the DUT, registered read port for readback.
  logic [WIDTH-1:0] ram [0:MEMW-1];
  logic [ADDRW-1:0] rd_addr = '0;
  logic [WIDTH-1:0] rd_data;
  always @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
    rd_data <= ram[rd_addr];
  end

  typedef struct {
    logic [ADDRW-1:0] addr;
    logic [WIDTH-1:0] data;
    int               cyc;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  wr_t mon_w;
  int  fd_cnt = 0, err_cnt = 0, overlap_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        mon_w.addr = wr_addr;
        mon_w.data = wr_data;
        mon_w.cyc  = cyc;
        got_q.push_back(mon_w);
      end
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (err_sync) err_cnt <= err_cnt + 1;
      if (frame_done && err_sync) overlap_cnt <= overlap_cnt + 1;
    end
  end

  // Reference model: bank bookkeeping plus expected RAM image.
  logic [WIDTH-1:0] exp_mem [0:MEMW-1];
  int m_wr_bank = 0;
  int m_rd_bank = 1;
  int compared = 0;
  int mism = 0;
  int gap_pct = 0;
  int last_accept_cyc = 0;
  int first_accept_cyc = 0;
  int first_bad = -1;

  function automatic void expect_pixel(input int bank, input int x, input int y,
                                       input logic [WIDTH-1:0] d);
    wr_t w;
    w.addr = ADDRW'(bank * BANK_SPAN + y * H_RES + x);
    w.data = d;
    w.cyc  = 0;
    exp_q.push_back(w);
    exp_mem[w.addr] = d;
  endfunction

  function automatic void model_frame_done();
    m_rd_bank = m_wr_bank;
    m_wr_bank = 1 - m_wr_bank;
  endfunction

  function automatic int count_write_diffs();
    int bad = 0;
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    first_bad = -1;
    if (got_q.size() != exp_q.size()) begin
      bad = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size()
                                           : exp_q.size() - got_q.size();
      first_bad = n;
    end
    for (int i = 0; i < n; i++) begin
      if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data) begin
        bad++;
        if (first_bad < 0 || i < first_bad) first_bad = i;
      end
    end
    return bad;
  endfunction

  task automatic beat(input logic [WIDTH-1:0] d, input bit sof, input bit eol);
    int n = 0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct && n < 16) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = WIDTH'($urandom);
      s_sof   = 1'($urandom);
      s_eol   = 1'($urandom);
      n++;
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    s_eol   = eol;
    n = 0;
    while (!s_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      $display("FAIL ready_timeout s_ready=%0b required=1 within 8 cycles", s_ready);
      mism++;
      compared++;
    end
    last_accept_cyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_eol   = 1'b0;
    end
  endtask

  task automatic send_range(input int base, input int from, input int to, input int bank);
    for (int p = from; p < to; p++) begin
      int x;
      int y;
      x = p % H_RES;
      y = p / H_RES;
      beat(WIDTH'(base + p), p == 0, x == H_RES - 1);
      if (p == from) first_accept_cyc = last_accept_cyc;
      expect_pixel(bank, x, y, WIDTH'(base + p));
    end
  endtask

  task automatic read_word(input logic [ADDRW-1:0] a, output logic [WIDTH-1:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic clear_scoreboard();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; s_eol = 1'b0;
    repeat (3) @(negedge clk);
    if (wr_en !== 1'b0) begin $display("FAIL reset_wr_en got=%0b want=0", wr_en); mism++; end
    compared++;
    if (wr_addr !== '0) begin $display("FAIL reset_wr_addr got=%0d want=0", wr_addr); mism++; end
    compared++;
    if (wr_data !== '0) begin $display("FAIL reset_wr_data got=%0d want=0", wr_data); mism++; end
    compared++;
    if (rd_bank !== 1'b1) begin $display("FAIL reset_rd_bank got=%0b want=1", rd_bank); mism++; end
    compared++;
    if (frame_done !== 1'b0) begin $display("FAIL reset_frame_done got=%0b want=0", frame_done); mism++; end
    compared++;
    if (err_sync !== 1'b0) begin $display("FAIL reset_err_sync got=%0b want=0", err_sync); mism++; end
    compared++;
    if (s_ready !== 1'b1) begin $display("FAIL reset_s_ready got=%0b want=1", s_ready); mism++; end
    compared++;
    rst_n = 1'b1;
    idle(2);
    $display("test_reset: done");
  endtask

  task automatic test_first_frame();
    int fd0 = fd_cnt;
    int er0 = err_cnt;
    int bad;
    int lat;
    int span;
    clear_scoreboard();
    gap_pct = 0;
    send_range(0, 0, DEPTH, m_wr_bank);
    idle(4);
    model_frame_done();
    bad = count_write_diffs();
    if (bad != 0) begin $display("FAIL f1_writes bad=%0d first_bad=%0d got_n=%0d want_n=%0d", bad, first_bad, got_q.size(), exp_q.size()); mism++; end
    compared++;
    lat = (got_q.size() > 0) ? got_q[0].cyc - first_accept_cyc : -1;
    if (lat != 0) begin $display("FAIL f1_latency got=%0d want=0 cycles after accept edge", lat); mism++; end
    compared++;
    span = (got_q.size() > 0) ? got_q[got_q.size()-1].cyc - got_q[0].cyc : -1;
    if (span != DEPTH - 1) begin $display("FAIL f1_throughput got=%0d want=%0d", span, DEPTH - 1); mism++; end
    compared++;
    if (fd_cnt - fd0 != 1) begin $display("FAIL f1_frame_done got=%0d want=1", fd_cnt - fd0); mism++; end
    compared++;
    if (err_cnt - er0 != 0) begin $display("FAIL f1_err_sync got=%0d want=0", err_cnt - er0); mism++; end
    compared++;
    if (rd_bank !== 1'(m_rd_bank)) begin $display("FAIL f1_rd_bank got=%0b want=%0d", rd_bank, m_rd_bank); mism++; end
    compared++;
    if (wr_en !== 1'b0) begin $display("FAIL f1_wr_en_idle got=%0b want=0", wr_en); mism++; end
    compared++;
    $display("test_first_frame: writes=%0d rd_bank=%0b", got_q.size(), rd_bank);
  endtask

  task automatic test_second_frame();
    int fd0 = fd_cnt;
    int bad;
    logic [WIDTH-1:0] d;
    logic [ADDRW-1:0] a;
    clear_scoreboard();
    gap_pct = 0;
    send_range(1000, 0, DEPTH, m_wr_bank);
    idle(4);
    model_frame_done();
    bad = count_write_diffs();
    if (bad != 0) begin $display("FAIL f2_writes bad=%0d first_bad=%0d got_n=%0d want_n=%0d", bad, first_bad, got_q.size(), exp_q.size()); mism++; end
    compared++;
    if (fd_cnt - fd0 != 1) begin $display("FAIL f2_frame_done got=%0d want=1", fd_cnt - fd0); mism++; end
    compared++;
    if (rd_bank !== 1'(m_rd_bank)) begin $display("FAIL f2_rd_bank got=%0b want=%0d", rd_bank, m_rd_bank); mism++; end
    compared++;
    for (int i = 0; i < 8; i++) begin
      a = ADDRW'((i % 2) * BANK_SPAN + $urandom_range(DEPTH - 1));
      read_word(a, d);
      if (d !== exp_mem[a]) begin $display("FAIL f2_readback addr=%0d got=%0d want=%0d", a, d, exp_mem[a]); mism++; end
      compared++;
    end
    $display("test_second_frame: writes=%0d rd_bank=%0b", got_q.size(), rd_bank);
  endtask

  task automatic test_no_sof();
    int fd0 = fd_cnt;
    int bad;
    int dropped;
    clear_scoreboard();
    gap_pct = 0;
    for (int i = 0; i < 10; i++) beat(WIDTH'($urandom), 1'b0, 1'($urandom));
    idle(3);
    dropped = got_q.size();
    if (dropped != 0) begin $display("FAIL nosof_dropped writes=%0d want=0", dropped); mism++; end
    compared++;
    clear_scoreboard();
    send_range(2000, 0, DEPTH, m_wr_bank);
    idle(4);
    model_frame_done();
    bad = count_write_diffs();
    if (bad != 0) begin $display("FAIL nosof_writes bad=%0d first_bad=%0d got_n=%0d want_n=%0d", bad, first_bad, got_q.size(), exp_q.size()); mism++; end
    compared++;
    if (fd_cnt - fd0 != 1) begin $display("FAIL nosof_frame_done got=%0d want=1", fd_cnt - fd0); mism++; end
    compared++;
    if (rd_bank !== 1'(m_rd_bank)) begin $display("FAIL nosof_rd_bank got=%0b want=%0d", rd_bank, m_rd_bank); mism++; end
    compared++;
    $display("test_no_sof: writes=%0d rd_bank=%0b", got_q.size(), rd_bank);
  endtask

  task automatic test_eol_error();
    int fd0 = fd_cnt;
    int er0 = err_cnt;
    int bad;
    int n_after;
    clear_scoreboard();
    gap_pct = 0;
    send_range(4000, 0, 5, m_wr_bank);
    beat(WIDTH'(4005), 1'b0, 1'b1);
    idle(3);
    if (err_cnt - er0 != 1) begin $display("FAIL early_eol_err got=%0d want=1", err_cnt - er0); mism++; end
    compared++;
    bad = count_write_diffs();
    if (bad != 0) begin $display("FAIL early_eol_writes bad=%0d got_n=%0d want_n=%0d", bad, got_q.size(), exp_q.size()); mism++; end
    compared++;
    n_after = got_q.size();
    beat(WIDTH'(4100), 1'b0, 1'b0);
    idle(3);
    if (got_q.size() != n_after) begin $display("FAIL early_eol_idle writes=%0d want=%0d", got_q.size(), n_after); mism++; end
    compared++;
    send_range(4200, 0, H_RES - 1, m_wr_bank);
    beat(WIDTH'(4200 + H_RES - 1), 1'b0, 1'b0);
    idle(3);
    if (err_cnt - er0 != 2) begin $display("FAIL missing_eol_err got=%0d want=2", err_cnt - er0); mism++; end
    compared++;
    bad = count_write_diffs();
    if (bad != 0) begin $display("FAIL missing_eol_writes bad=%0d got_n=%0d want_n=%0d", bad, got_q.size(), exp_q.size()); mism++; end
    compared++;
    if (fd_cnt - fd0 != 0) begin $display("FAIL eol_err_frame_done got=%0d want=0", fd_cnt - fd0); mism++; end
    compared++;
    if (rd_bank !== 1'(m_rd_bank)) begin $display("FAIL eol_err_rd_bank got=%0b want=%0d", rd_bank, m_rd_bank); mism++; end
    compared++;
    $display("test_eol_error: errors=%0d writes=%0d", err_cnt - er0, got_q.size());
  endtask

  task automatic test_sof_mid();
    int fd0 = fd_cnt;
    int er0 = err_cnt;
    int bad;
    logic [WIDTH-1:0] d;
    logic [ADDRW-1:0] a;
    int bank;
    clear_scoreboard();
    gap_pct = 0;
    bank = m_wr_bank;
    send_range(5000, 0, 3 * H_RES + 5, bank);
    send_range(6000, 0, DEPTH, bank);
    idle(4);
    model_frame_done();
    bad = count_write_diffs();
    if (bad != 0) begin $display("FAIL sofmid_writes bad=%0d first_bad=%0d got_n=%0d want_n=%0d", bad, first_bad, got_q.size(), exp_q.size()); mism++; end
    compared++;
    if (err_cnt - er0 != 1) begin $display("FAIL sofmid_err got=%0d want=1", err_cnt - er0); mism++; end
    compared++;
    if (fd_cnt - fd0 != 1) begin $display("FAIL sofmid_frame_done got=%0d want=1", fd_cnt - fd0); mism++; end
    compared++;
    if (rd_bank !== 1'(m_rd_bank)) begin $display("FAIL sofmid_rd_bank got=%0b want=%0d", rd_bank, m_rd_bank); mism++; end
    compared++;
    for (int i = 0; i < 4; i++) begin
      a = ADDRW'(bank * BANK_SPAN + ((i == 0) ? 0 : $urandom_range(DEPTH - 1)));
      read_word(a, d);
      if (d !== exp_mem[a]) begin $display("FAIL sofmid_readback addr=%0d got=%0d want=%0d", a, d, exp_mem[a]); mism++; end
      compared++;
    end
    $display("test_sof_mid: writes=%0d rd_bank=%0b", got_q.size(), rd_bank);
  endtask

  task automatic test_reset_mid();
    int fd0;
    int bad;
    logic [WIDTH-1:0] d;
    logic [ADDRW-1:0] a;
    clear_scoreboard();
    gap_pct = 50;
    send_range(7000, 0, 400, m_wr_bank);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    s_valid = 1'b0;
    #1;
    if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin
      $display("FAIL rstmid_write_port got en=%0b addr=%0d data=%0d want 0/0/0", wr_en, wr_addr, wr_data); mism++;
    end
    compared++;
    if (rd_bank !== 1'b1) begin $display("FAIL rstmid_rd_bank got=%0b want=1", rd_bank); mism++; end
    compared++;
    if (frame_done !== 1'b0 || err_sync !== 1'b0) begin
      $display("FAIL rstmid_pulses got fd=%0b err=%0b want 0/0", frame_done, err_sync); mism++;
    end
    compared++;
    m_wr_bank = 0;
    m_rd_bank = 1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    clear_scoreboard();
    fd0 = fd_cnt;
    send_range(8000, 0, DEPTH, m_wr_bank);
    idle(4);
    model_frame_done();
    bad = count_write_diffs();
    if (bad != 0) begin $display("FAIL rstmid_writes bad=%0d first_bad=%0d got_n=%0d want_n=%0d", bad, first_bad, got_q.size(), exp_q.size()); mism++; end
    compared++;
    if (fd_cnt - fd0 != 1) begin $display("FAIL rstmid_frame_done got=%0d want=1", fd_cnt - fd0); mism++; end
    compared++;
    if (rd_bank !== 1'(m_rd_bank)) begin $display("FAIL rstmid_rd_bank_after got=%0b want=%0d", rd_bank, m_rd_bank); mism++; end
    compared++;
    for (int i = 0; i < 4; i++) begin
      a = ADDRW'($urandom_range(DEPTH - 1));
      read_word(a, d);
      if (d !== exp_mem[a]) begin $display("FAIL rstmid_readback addr=%0d got=%0d want=%0d", a, d, exp_mem[a]); mism++; end
      compared++;
    end
    gap_pct = 0;
    $display("test_reset_mid: writes=%0d rd_bank=%0b", got_q.size(), rd_bank);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_sof = 1'b0;
    s_eol = 1'b0;
    test_reset();
    test_first_frame();
    test_second_frame();
    test_no_sof();
    test_eol_error();
    test_sof_mid();
    test_reset_mid();
    if (overlap_cnt != 0) begin $display("FAIL done_err_overlap got=%0d want=0", overlap_cnt); mism++; end
    compared++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
